// File: rtl/store_pkg.sv
// Shared definitions for the store path: size encodings, unit FSM states
// and common byte-enable patterns. Imported by store_lane_mux and
// store_narrow_unit.
package store_pkg;

  // Store size encodings as presented on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    ERR   = 2'b10
  } state_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_ALL  = 4'b1111;

endpackage

// File: rtl/store_lane_mux.sv
// store_lane_mux: combinational narrowing of a register value onto the
// byte lanes of a 32-bit little-endian data memory.
//
// Ports:
//   addr    in   2  low address bits selecting the byte lane
//   size    in   2  store size (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL)
//   data    in  32  register value to store
//   wdata   out 32  lane-replicated write data
//   be      out  4  byte enables (bit i covers bits [8i+7:8i])
//   illegal out  1  misaligned address or illegal size
//
// Also used by the store-buffer path, so it carries no state.
module store_lane_mux
  import store_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        illegal
);

  always_comb begin
    wdata   = data;
    be      = BE_NONE;
    illegal = 1'b0;
    case (size)
      SZ_BYTE: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << addr;
      end
      SZ_HALF: begin
        wdata   = {2{data[15:0]}};
        be      = addr[1] ? 4'b1100 : 4'b0011;
        illegal = addr[0];
      end
      SZ_WORD: begin
        wdata   = data;
        be      = BE_ALL;
        illegal = (addr != 2'b00);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
    // Never advertise lanes for a store that will not be issued
    if (illegal) be = BE_NONE;
  end

endmodule

// File: rtl/store_narrow_unit.sv
// store_narrow_unit: MEM-stage store path. Accepts a store request, narrows
// the register value to the addressed byte lanes, and runs a req/ack
// handshake with data memory. Misaligned or illegal-size stores are flagged
// with a one-cycle misalign pulse and never reach memory.
//
// Optional feature macro: STORE_TIMEOUT_EN
//   When defined, an ISSUE that sees no mem_ack for TIMEOUT cycles is
//   abandoned: mem_req drops, the unit returns to IDLE and misalign pulses
//   as a bus-error flag. When undefined, ISSUE waits indefinitely.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset_n    in   1  asynchronous active-low reset
//   req_valid  in   1  store request from pipeline
//   req_ready  out  1  unit idle, can accept a request
//   req_addr   in  32  byte address of store
//   req_data   in  32  register value to store
//   req_size   in   2  00 byte, 01 half, 10 word, 11 illegal
//   mem_req    out  1  write request to data memory
//   mem_addr   out 32  word-aligned store address
//   mem_wdata  out 32  lane-replicated write data
//   mem_be     out  4  byte enables
//   mem_ack    in   1  memory accepted the write
//   done       out  1  one-cycle pulse: store completed
//   misalign   out  1  one-cycle pulse: store rejected (or timed out)
//   stall      out  1  pipeline hold while the unit is busy
module store_narrow_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        done,
  output logic        misalign,
  output logic        stall
);

  import store_pkg::*;

  state_t      state_q, state_d;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;
  logic        lane_illegal;

  logic        mem_req_d;
  logic [31:0] mem_addr_d;
  logic [31:0] mem_wdata_d;
  logic [3:0]  mem_be_d;
  logic        done_d;
  logic        misalign_d;
  logic        ack_seen;

  store_lane_mux u_lane_mux (
    .addr    (req_addr[1:0]),
    .size    (req_size),
    .data    (req_data),
    .wdata   (lane_wdata),
    .be      (lane_be),
    .illegal (lane_illegal)
  );

  assign req_ready = (state_q == IDLE);
  assign stall     = (state_q != IDLE);
  // mem_ack only counts while a request is actually outstanding
  assign ack_seen  = mem_req && mem_ack;

`ifdef STORE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Held at zero outside ISSUE, so it is already clear on entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state_q != ISSUE) begin
      tmo_cnt <= '0;
    end else if (!ack_seen) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Fires on the TIMEOUT-th ISSUE cycle without ack
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_be_d    = mem_be;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (lane_illegal) begin
            state_d    = ERR;
            misalign_d = 1'b1;
          end else begin
            state_d     = ISSUE;
            mem_req_d   = 1'b1;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = lane_wdata;
            mem_be_d    = lane_be;
          end
        end
      end
      ISSUE: begin
        // An ack coinciding with the timeout still completes the store
        if (ack_seen) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_be_d  = BE_NONE;
          done_d    = 1'b1;
        end
`ifdef STORE_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_be_d   = BE_NONE;
          misalign_d = 1'b1;
        end
`endif
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_be_d  = BE_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory-side outputs are registered so they stay stable until ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= BE_NONE;
      done      <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      mem_req   <= mem_req_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_be    <= mem_be_d;
      done      <= done_d;
      misalign  <= misalign_d;
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed self-checking bench for store_narrow_unit.
module tb_store_narrow_unit;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        done;
  logic        misalign;
  logic        stall;

  int checks = 0;
  int errors = 0;

  store_narrow_unit #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .done      (done),
    .misalign  (misalign),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge; returns in the first cycle after accept
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    step();
    req_valid = 1'b0;
  endtask

  logic [31:0] bad_addr [3];
  logic [1:0]  bad_size [3];

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_size  = 2'b00;
    mem_ack   = 1'b0;
    bad_addr[0] = 32'h3001; bad_size[0] = 2'b10;
    bad_addr[1] = 32'h3003; bad_size[1] = 2'b01;
    bad_addr[2] = 32'h3000; bad_size[2] = 2'b11;

    // Reset state
    #12;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_done_mis", {30'd0, done, misalign}, 32'd0);
    reset_n = 1'b1;
    step();
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // sb to the top lane, ack after 2 cycles
    send(32'h1003, 32'hDEADBEEF, 2'b00);
    chk("sb_req", {31'd0, mem_req}, 32'd1);
    chk("sb_addr", mem_addr, 32'h1000);
    chk("sb_be", {28'd0, mem_be}, 32'h8);
    chk("sb_wdata", mem_wdata, 32'hEFEFEFEF);
    chk("sb_busy", {30'd0, req_ready, stall}, 32'd1);
    step();
    chk("sb_hold", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("sb_done", {30'd0, done, misalign}, 32'd2);
    chk("sb_drop", {27'd0, mem_req, mem_be}, 32'd0);
    chk("sb_ready", {30'd0, req_ready, stall}, 32'd2);
    step();
    chk("sb_done_once", {31'd0, done}, 32'd0);

    // sh upper half, same-cycle ack, then back-to-back sb
    send(32'h2002, 32'h1234ABCD, 2'b01);
    chk("sh_be", {28'd0, mem_be}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hABCDABCD);
    chk("sh_addr", mem_addr, 32'h2000);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("sh_done", {31'd0, done}, 32'd1);
    chk("sh_ready", {31'd0, req_ready}, 32'd1);
    send(32'h2001, 32'h00000055, 2'b00);
    chk("b2b_req", {31'd0, mem_req}, 32'd1);
    chk("b2b_be", {28'd0, mem_be}, 32'h2);
    chk("b2b_wdata", mem_wdata, 32'h55555555);
    chk("b2b_done_off", {31'd0, done}, 32'd0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("b2b_done", {31'd0, done}, 32'd1);
    step();

    // Misaligned and illegal stores
    for (int i = 0; i < 3; i++) begin
      send(bad_addr[i], 32'hFFFFFFFF, bad_size[i]);
      chk($sformatf("bad%0d_mis", i), {30'd0, misalign, done}, 32'd2);
      chk($sformatf("bad%0d_req", i), {27'd0, mem_req, mem_be}, 32'd0);
      chk($sformatf("bad%0d_stall", i), {30'd0, stall, req_ready}, 32'd2);
      step();
      chk($sformatf("bad%0d_clear", i), {28'd0, misalign, mem_req, stall, req_ready}, 32'd1);
    end

    // Reset in the middle of an outstanding store
    send(32'h4000, 32'hCAFEF00D, 2'b10);
    chk("rw_be", {28'd0, mem_be}, 32'hF);
    chk("rw_wdata", mem_wdata, 32'hCAFEF00D);
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rw_async_req", {31'd0, mem_req}, 32'd0);
    chk("rw_async_data", mem_wdata | mem_addr, 32'd0);
    chk("rw_async_flags", {26'd0, mem_be, done, misalign}, 32'd0);
    #3;
    reset_n = 1'b1;
    step();
    chk("rw_after", {28'd0, req_ready, stall, done, mem_req}, 32'h8);

    // Spurious ack while idle
    mem_ack = 1'b1;
    step();
    step();
    chk("spur_idle", {28'd0, req_ready, stall, done, mem_req}, 32'h8);
    mem_ack = 1'b0;

    // req_valid toggling while ISSUE must not disturb the store
    send(32'h5000, 32'h11223344, 2'b10);
    req_valid = 1'b1;
    req_addr  = 32'h9001;
    req_data  = 32'h0;
    req_size  = 2'b11;
    step();
    chk("tog_addr1", mem_addr, 32'h5000);
    chk("tog_wdata1", mem_wdata, 32'h11223344);
    req_valid = 1'b0;
    step();
    chk("tog_state", {28'd0, mem_req, stall, misalign, done}, 32'hC);
    chk("tog_be", {28'd0, mem_be}, 32'hF);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("tog_done", {31'd0, done}, 32'd1);
    chk("tog_addr_hold", mem_addr, 32'h5000);
    step();

`ifdef STORE_TIMEOUT_EN
    // No ack: abandoned after 4 ISSUE cycles
    send(32'h6000, 32'hA5A5A5A5, 2'b10);
    for (int c = 1; c < 4; c++) begin
      chk($sformatf("tmo_wait%0d", c), {31'd0, mem_req}, 32'd1);
      step();
    end
    chk("tmo_wait4", {31'd0, mem_req}, 32'd1);
    step();
    chk("tmo_drop", {28'd0, mem_req, misalign, done, req_ready}, 32'h5);
    step();
    chk("tmo_clear", {31'd0, misalign}, 32'd0);

    // Ack on the 4th cycle wins over the timeout
    send(32'h6004, 32'h5A5A5A5A, 2'b10);
    step();
    step();
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("tmo_ack_win", {29'd0, mem_req, misalign, done}, 32'd1);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
